fire4_squeeze_ofm_writer: RTL and testbench

FIRE4_SQUEEZE_OFM_WRITER -- requirements
Module: fire4_squeeze_ofm_writer

---
 rtl/fire4_squeeze_ofm_writer.sv | 149 ++++++++++++++
 tb/tb_fire4_squeeze_ofm_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire4_squeeze_ofm_writer.sv
// Fire4 squeeze OFM writer: captures one pixel's worth of squeeze-layer channel
// outputs and serializes them into the feature RAM in channel-major order.
//
// Ports:
//   clk                  - single clock, rising edge
//   rst                  - asynchronous active-low reset
//   start                - pulse: re-arm for a new layer pass (clears pix/chan/overflow)
//   fire4_squeeze_sample - pulse: ofm is valid this cycle
//   ofm[0:DSP_NO-1]      - channel outputs for one pixel
//   wr_en/wr_addr/wr_data- feature-RAM write port (combinational from registered state)
//   ram_feedback         - one-cycle pulse after the last write of the layer
//   overflow             - sticky flag: a sample arrived mid-drain and was dropped
module fire4_squeeze_ofm_writer #(
    parameter int unsigned WOUT   = 32,
    parameter int unsigned DSP_NO = 32,
    parameter int unsigned WIDTH  = 16,
    localparam int unsigned AW    = $clog2(DSP_NO * WOUT ** 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fire4_squeeze_sample,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             ram_feedback,
    output logic             overflow
);

    localparam int unsigned PIX_N = WOUT * WOUT;
    localparam int unsigned PW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam int unsigned CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_N - 1);
    localparam logic [CW-1:0] CHAN_LAST = CW'(DSP_NO - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [PW-1:0]    pix, pix_nxt;
    logic [CW-1:0]    chan, chan_nxt;
    logic             overflow_nxt;
    logic             ram_feedback_nxt;
    logic             load;
    logic [WIDTH-1:0] buffer [0:DSP_NO-1];

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pix          <= '0;
            chan         <= '0;
            overflow     <= 1'b0;
            ram_feedback <= 1'b0;
        end else begin
            state        <= state_nxt;
            pix          <= pix_nxt;
            chan         <= chan_nxt;
            overflow     <= overflow_nxt;
            ram_feedback <= ram_feedback_nxt;
        end
    end

    // Pixel capture buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < int'(DSP_NO); c++) begin
                buffer[c] <= '0;
            end
        end else if (load) begin
            for (int c = 0; c < int'(DSP_NO); c++) begin
                buffer[c] <= ofm[c];
            end
        end
    end

    // Next-state logic; start overrides everything, including a concurrent sample
    always_comb begin
        state_nxt        = state;
        pix_nxt          = pix;
        chan_nxt         = chan;
        overflow_nxt     = overflow;
        ram_feedback_nxt = 1'b0;
        load             = 1'b0;

        if (start) begin
            state_nxt    = S_IDLE;
            pix_nxt      = '0;
            chan_nxt     = '0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire4_squeeze_sample) begin
                        load      = 1'b1;
                        chan_nxt  = '0;
                        state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (chan == CHAN_LAST) begin
                        // Final channel of this pixel: advance pix; a new sample
                        // may chain directly unless this was the layer's last pixel.
                        chan_nxt = '0;
                        if (pix == PIX_LAST) begin
                            pix_nxt          = '0;
                            state_nxt        = S_DONE;
                            ram_feedback_nxt = 1'b1;
                        end else begin
                            pix_nxt = pix + PW'(1);
                            if (fire4_squeeze_sample) begin
                                load = 1'b1;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end
                    end else begin
                        chan_nxt = chan + CW'(1);
                        if (fire4_squeeze_sample) begin
                            overflow_nxt = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Write port: channel-major address chan*WOUT^2 + pix, zero when idle
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == S_DRAIN) begin
            wr_en   = 1'b1;
            wr_addr = AW'(chan) * AW'(PIX_N) + AW'(pix);
            wr_data = buffer[chan];
        end
    end

endmodule

// File: tb/tb_fire4_squeeze_ofm_writer.sv
// Testbench for fire4_squeeze_ofm_writer: a small instance (WOUT=2, DSP_NO=4)
// checked cycle-by-cycle against a write-queue reference model, plus a
// default-size instance run through one full layer with a RAM scoreboard.
module tb_fire4_squeeze_ofm_writer;

    localparam int S_DSP = 4;
    localparam int S_P   = 4;
    localparam int S_AW  = 4;
    localparam int S_MAX = S_DSP * S_P - 1;
    localparam int B_DSP = 32;
    localparam int B_P   = 1024;
    localparam int B_AW  = 15;
    localparam int B_N   = B_DSP * B_P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              s_start, s_sample;
    logic [15:0]       s_ofm [0:S_DSP-1];
    logic              s_wr_en;
    logic [S_AW-1:0]   s_wr_addr;
    logic [15:0]       s_wr_data;
    logic              s_fb, s_ovf;

    logic              b_start, b_sample;
    logic [15:0]       b_ofm [0:B_DSP-1];
    logic              b_wr_en;
    logic [B_AW-1:0]   b_wr_addr;
    logic [15:0]       b_wr_data;
    logic              b_fb, b_ovf;

    fire4_squeeze_ofm_writer #(.WOUT(2), .DSP_NO(4), .WIDTH(16)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .fire4_squeeze_sample(s_sample),
        .ofm(s_ofm), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .ram_feedback(s_fb), .overflow(s_ovf)
    );

    fire4_squeeze_ofm_writer u_big (
        .clk(clk), .rst(rst), .start(b_start), .fire4_squeeze_sample(b_sample),
        .ofm(b_ofm), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .ram_feedback(b_fb), .overflow(b_ovf)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: an accepted sample schedules DSP_NO writes, one per cycle
    // starting next cycle; a sample is accepted only when at most one pending
    // write remains and fewer than WOUT^2 pixels have been scheduled.
    int          q_addr[$];
    logic [15:0] q_data[$];
    int          m_sched;
    bit          m_ovf, m_fb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_addr.delete(); q_data.delete();
            m_sched = 0; m_ovf = 0; m_fb = 0;
        end else begin
            m_fb = 0;
            if (s_start) begin
                q_addr.delete(); q_data.delete();
                m_sched = 0; m_ovf = 0;
            end else begin
                if (q_addr.size() > 0) begin
                    if (q_addr[0] == S_MAX) m_fb = 1;
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
                if (s_sample) begin
                    if (q_addr.size() > 0) begin
                        m_ovf = 1;
                    end else if (m_sched < S_P) begin
                        for (int c = 0; c < S_DSP; c++) begin
                            q_addr.push_back(c * S_P + m_sched);
                            q_data.push_back(s_ofm[c]);
                        end
                        m_sched++;
                    end
                end
            end
        end
    end

    bit chk_s  = 0;
    bit log_en = 0;
    int log_q[$];
    int fb_cnt = 0;

    always @(negedge clk) begin
        if (chk_s) begin
            logic en;
            en = (q_addr.size() > 0);
            check("s_wr_en", 32'(s_wr_en), 32'(en));
            check("s_wr_addr", 32'(s_wr_addr), en ? 32'(q_addr[0]) : 32'd0);
            check("s_wr_data", 32'(s_wr_data), en ? 32'(q_data[0]) : 32'd0);
            check("s_ram_feedback", 32'(s_fb), 32'(m_fb));
            check("s_overflow", 32'(s_ovf), 32'(m_ovf));
        end
        if (log_en && s_wr_en) log_q.push_back(int'(s_wr_addr));
        if (s_fb) fb_cnt++;
    end

    // Default-size scoreboard: expected RAM image plus write-once tracking
    logic [15:0] b_exp  [0:B_N-1];
    bit          b_seen [0:B_N-1];
    bit b_chk      = 0;
    bit b_prev_max = 0;
    int b_wr_cnt   = 0;
    int b_fb_cnt   = 0;

    always @(negedge clk) begin
        if (b_chk) begin
            if (b_wr_en) begin
                check("b_wr_data", 32'(b_wr_data), 32'(b_exp[b_wr_addr]));
                check("b_addr_once", 32'(b_seen[b_wr_addr]), 32'd0);
                b_seen[b_wr_addr] = 1;
                b_wr_cnt++;
            end
            if (b_fb) begin
                b_fb_cnt++;
                check("b_fb_after_last", 32'(b_prev_max), 32'd1);
            end
            b_prev_max = b_wr_en && (b_wr_addr == B_AW'(B_N - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_s();
        s_sample = 1'b1;
        tick(1);
        s_sample = 1'b0;
    endtask

    task automatic pulse_start();
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
    endtask

    task automatic rand_ofm();
        for (int c = 0; c < S_DSP; c++) s_ofm[c] = 16'($urandom);
    endtask

    int layer1[$];
    int srt[$];

    initial begin
        rst = 1'b0;
        s_start = 1'b0; s_sample = 1'b0;
        b_start = 1'b0; b_sample = 1'b0;
        for (int c = 0; c < S_DSP; c++) s_ofm[c] = '0;
        for (int c = 0; c < B_DSP; c++) b_ofm[c] = '0;
        for (int a = 0; a < B_N; a++) begin
            b_exp[a] = '0;
            b_seen[a] = 0;
        end

        // Reset state
        tick(3);
        check("rst_wr_en", 32'(s_wr_en), 32'd0);
        check("rst_wr_addr", 32'(s_wr_addr), 32'd0);
        check("rst_wr_data", 32'(s_wr_data), 32'd0);
        check("rst_fb", 32'(s_fb), 32'd0);
        check("rst_ovf", 32'(s_ovf), 32'd0);
        check("rst_b_wr_en", 32'(b_wr_en), 32'd0);
        check("rst_b_ovf", 32'(b_ovf), 32'd0);
        rst = 1'b1;
        tick(1);
        chk_s = 1; log_en = 1; fb_cnt = 0; log_q.delete();

        // Single pixel, no start needed after reset
        s_ofm[0] = 16'd10; s_ofm[1] = 16'd20; s_ofm[2] = 16'd30; s_ofm[3] = 16'd40;
        pulse_s();
        for (int i = 0; i < S_DSP; i++) begin
            check("px0_wr_en", 32'(s_wr_en), 32'd1);
            check("px0_addr", 32'(s_wr_addr), 32'(i * 4));
            check("px0_data", 32'(s_wr_data), 32'((i + 1) * 10));
            tick(1);
        end
        check("px0_idle", 32'(s_wr_en), 32'd0);

        // Rest of the layer, samples 10 cycles apart
        for (int p = 1; p < S_P; p++) begin
            tick(5);
            rand_ofm();
            pulse_s();
            check("layer_first_addr", 32'(s_wr_addr), 32'(p));
            tick(4);
        end
        check("layer_fb_pulse", 32'(s_fb), 32'd1);
        tick(1);
        check("layer_fb_once", 32'(s_fb), 32'd0);
        check("layer_fb_cnt", 32'(fb_cnt), 32'd1);
        check("layer_writes", 32'(log_q.size()), 32'd16);
        srt = log_q;
        srt.sort();
        for (int i = 0; i < srt.size(); i++) check("layer_addr_cover", 32'(srt[i]), 32'(i));
        layer1 = log_q;

        // Sample in DONE is ignored
        rand_ofm();
        pulse_s();
        check("done_no_write", 32'(s_wr_en), 32'd0);
        tick(3);
        check("done_writes", 32'(log_q.size()), 32'd16);
        check("done_ovf", 32'(s_ovf), 32'd0);

        // Back-to-back: second sample on the chan=3 cycle chains
        pulse_start();
        log_q.delete();
        rand_ofm();
        pulse_s();
        tick(3);
        rand_ofm();
        pulse_s();
        tick(6);
        check("b2b_writes", 32'(log_q.size()), 32'd8);
        check("b2b_addr4", 32'(log_q[4]), 32'd1);
        check("b2b_addr7", 32'(log_q[7]), 32'd13);
        check("b2b_ovf", 32'(s_ovf), 32'd0);

        // Second sample on the chan=1 cycle is dropped
        rand_ofm();
        pulse_s();
        tick(1);
        rand_ofm();
        pulse_s();
        tick(1);
        check("drop_ovf", 32'(s_ovf), 32'd1);
        tick(5);
        check("drop_ovf_sticky", 32'(s_ovf), 32'd1);
        check("drop_writes", 32'(log_q.size()), 32'd12);

        // start clears overflow; concurrent sample is ignored
        pulse_start();
        check("start_clr_ovf", 32'(s_ovf), 32'd0);
        s_start = 1'b1; s_sample = 1'b1;
        tick(1);
        s_start = 1'b0; s_sample = 1'b0;
        check("start_sample_ignored", 32'(s_wr_en), 32'd0);

        // Restarted full layer repeats the same address sequence
        log_q.delete(); fb_cnt = 0;
        for (int p = 0; p < S_P; p++) begin
            rand_ofm();
            pulse_s();
            tick(9);
        end
        check("relayer_writes", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < layer1.size() && i < log_q.size(); i++)
            check("relayer_addr", 32'(log_q[i]), 32'(layer1[i]));
        check("relayer_fb_cnt", 32'(fb_cnt), 32'd1);

        // Mid-drain asynchronous reset
        pulse_start();
        rand_ofm();
        pulse_s();
        tick(2);
        check("mid_rst_pre", 32'(s_wr_addr), 32'd8);
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(s_wr_en), 32'd0);
        check("mid_rst_addr", 32'(s_wr_addr), 32'd0);
        check("mid_rst_data", 32'(s_wr_data), 32'd0);
        check("mid_rst_fb", 32'(s_fb), 32'd0);
        check("mid_rst_ovf", 32'(s_ovf), 32'd0);
        #1;
        rst = 1'b1;
        tick(1);
        rand_ofm();
        pulse_s();
        check("post_rst_addr", 32'(s_wr_addr), 32'd0);
        check("post_rst_data", 32'(s_wr_data), 32'(s_ofm[0]));
        tick(6);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s_start  = ($urandom_range(0, 63) == 0);
            s_sample = ($urandom_range(0, 2) == 0);
            rand_ofm();
            tick(1);
        end
        s_start = 1'b0; s_sample = 1'b0;
        tick(6);

        // Default-size full layer with chained samples every DSP_NO cycles
        b_chk = 1;
        for (int p = 0; p < B_P; p++) begin
            for (int c = 0; c < B_DSP; c++) begin
                b_ofm[c] = 16'($urandom);
                b_exp[c * B_P + p] = b_ofm[c];
            end
            b_sample = 1'b1;
            tick(1);
            b_sample = 1'b0;
            tick(B_DSP - 1);
        end
        tick(10);
        check("big_writes", 32'(b_wr_cnt), 32'(B_N));
        check("big_fb_cnt", 32'(b_fb_cnt), 32'd1);
        check("big_ovf", 32'(b_ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
